dmi_arbiter: RTL and testbench
==============================

// Module: dmi_arbiter
// PURPOSE
//  Shares the debug module's single DMI slave port between two DMI masters.
//  m0 is the JTAG DTM request/response path; m1 is a second debug master (system-side debug port).
//  Exactly one transaction is outstanding at a time. Requests are granted round-robin.
//  A response timeout returns an error to the master so a hung DM cannot lock out either master.
// PARAMETERS
//  ADDR_W    7     DMI address width; must equal `DBUS_ADDR_WIDTH
//  DATA_W    32    DMI data width; must equal `DBUS_DATA_WIDTH
//  TIMEOUT   1024  max cycles from DM request handshake to DM response; 0 = timeout disabled
//  (derived) M_W = ADDR_W+DATA_W+2 req bits {addr,data,op}; S_W = DATA_W+2 resp bits {data,op}
// PORTS
//  sys_clk        in   1    sole clock
//  sys_rstn       in   1    asynchronous reset, active low
//  mX_req_valid   in   1    X=0,1: master request valid
//  mX_req_ready   out  1    master request accepted
//  mX_req_bits    in   M_W  master request {addr,data,op}
//  mX_resp_valid  out  1    response to master valid
//  mX_resp_ready  in   1    master takes response
//  mX_resp_bits   out  S_W  response {data,op}
//  dm_req_valid   out  1    request to DM valid
//  dm_req_ready   in   1    DM accepts request
//  dm_req_bits    out  M_W  request to DM
//  dm_resp_valid  in   1    DM response valid
//  dm_resp_ready  out  1    arbiter takes DM response
//  dm_resp_bits   in   S_W  DM response
//  busy           out  1    state != IDLE
//  timeout_pulse  out  1    one cycle when a timeout fires
//  stray_pulse    out  1    one cycle when a DM response is discarded
// BEHAVIOUR
//  Reset: state=IDLE, req_buf=0, resp_buf=0, grant=0, last_grant=1, timer=0. All outputs 0.
//  FSM states: IDLE -> REQ -> WAIT -> RESP -> IDLE.
//  IDLE:
//   - Selection: if exactly one mX_req_valid, select X. If both, select X != last_grant.
//   - Asserts mX_req_ready for the selected X only, combinationally, in the same cycle.
//   - Latches req_bits into req_buf and X into grant. Next state = REQ.
//  REQ:
//   - dm_req_valid=1, dm_req_bits=req_buf, held stable until dm_req_ready.
//   - On handshake: timer=0, next state = WAIT.
//  WAIT:
//   - dm_resp_ready=1. timer increments each cycle.
//   - On dm_resp_valid: resp_buf=dm_resp_bits, next state = RESP.
//   - Else if TIMEOUT!=0 and timer==TIMEOUT-1: resp_buf={DATA_W'0, 2'b10}, timeout_pulse=1, next state = RESP.
//   - If dm_resp_valid and timeout coincide, the DM response wins and no pulse fires.
//  RESP:
//   - m[grant]_resp_valid=1, bits=resp_buf, held stable until m[grant]_resp_ready.
//   - On that handshake: last_grant=grant, next state = IDLE.
//   - The other master's resp_valid stays 0.
//  Stray responses:
//   - In IDLE and RESP, dm_resp_ready=1; any dm_resp_valid is dropped and stray_pulse=1.
//   - In REQ, dm_resp_ready=0.
//  Latency:
//   - Master accept at cycle N -> dm_req_valid at N+1.
//   - DM response at cycle K -> mX_resp_valid at K+1.
//   - Next grant no earlier than 1 cycle after the response handshake.
//  Width: timer is $clog2(TIMEOUT+1) bits and never wraps; it saturates in WAIT only.
//  No request is accepted while busy=1; mX_req_ready=0 outside IDLE.
//  Async reset in any state aborts the transaction silently; no response is issued to either master.
// TESTING
//  T1 m0 alone {addr=0x10,data=0,op=1}; DM ready at once, replies {0x12345678,00} 3 cycles later
//     -> dm_req_bits matches; m0_resp_bits={0x12345678,00}; m1_resp_valid never 1.
//  T2 m0,m1 both valid from reset, held for 4 transactions
//     -> grant order m0,m1,m0,m1; each resp_bits routed to its owner.
//  T3 TIMEOUT=16, DM never responds
//     -> timeout_pulse 16 cycles after DM handshake; m resp={0,2'b10}; busy drops after resp handshake.
//  T4 after T3, DM returns {0xDEAD,00} while IDLE
//     -> stray_pulse=1 for 1 cycle, no mX_resp_valid, next transaction unaffected.
//  T5 m1_resp_ready low 10 cycles with m0_req_valid=1
//     -> m1_resp_bits stable, m0_req_ready=0 until m1 handshake, m0 granted next cycle.
//  T6 sys_rstn low during WAIT
//     -> all outputs 0 immediately; after release, simultaneous m0/m1 request grants m0 first.

Source files
------------

// File: rtl/dmi_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : dmi_arbiter                                                       |
// | Brief  : Round-robin share of one DMI slave port between two DMI masters,  |
// |          one transaction outstanding, with response timeout.               |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module dmi_arbiter #(
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024,
  localparam int M_W    = ADDR_W + DATA_W + 2,
  localparam int S_W    = DATA_W + 2
) (
  input  logic           sys_clk,
  input  logic           sys_rstn,
  input  logic           m0_req_valid,
  output logic           m0_req_ready,
  input  logic [M_W-1:0] m0_req_bits,
  output logic           m0_resp_valid,
  input  logic           m0_resp_ready,
  output logic [S_W-1:0] m0_resp_bits,
  input  logic           m1_req_valid,
  output logic           m1_req_ready,
  input  logic [M_W-1:0] m1_req_bits,
  output logic           m1_resp_valid,
  input  logic           m1_resp_ready,
  output logic [S_W-1:0] m1_resp_bits,
  output logic           dm_req_valid,
  input  logic           dm_req_ready,
  output logic [M_W-1:0] dm_req_bits,
  input  logic           dm_resp_valid,
  output logic           dm_resp_ready,
  input  logic [S_W-1:0] dm_resp_bits,
  output logic           busy,
  output logic           timeout_pulse,
  output logic           stray_pulse
);

  localparam int              TMR_W      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit              c_TMO_EN   = (TIMEOUT != 0);
  localparam logic [TMR_W-1:0] c_TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0] c_TMR_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [M_W-1:0]   r_req_buf;
  logic [S_W-1:0]   r_resp_buf;
  logic             r_grant;
  logic             r_last_grant;
  logic [TMR_W-1:0] r_timer;

  logic w_sel0;
  logic w_sel1;
  logic w_timeout_hit;
  logic w_resp_hs;

  // On contention the master that was not served last wins.
  assign w_sel0        = m0_req_valid & (~m1_req_valid | r_last_grant);
  assign w_sel1        = m1_req_valid & (~m0_req_valid | ~r_last_grant);
  assign w_timeout_hit = c_TMO_EN && (r_timer == c_TMR_LAST);
  assign w_resp_hs     = (r_state == S_RESP) & (r_grant ? m1_resp_ready : m0_resp_ready);

  assign busy          = (r_state != S_IDLE);
  assign dm_req_bits   = r_req_buf;
  assign m0_resp_bits  = r_resp_buf;
  assign m1_resp_bits  = r_resp_buf;

  always_comb begin
    w_state_nxt   = r_state;
    m0_req_ready  = 1'b0;
    m1_req_ready  = 1'b0;
    m0_resp_valid = 1'b0;
    m1_resp_valid = 1'b0;
    dm_req_valid  = 1'b0;
    dm_resp_ready = 1'b0;
    timeout_pulse = 1'b0;
    stray_pulse   = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Reset holds the FSM in IDLE; keep its outputs quiet until release.
        if (sys_rstn) begin
          m0_req_ready  = w_sel0;
          m1_req_ready  = w_sel1;
          dm_resp_ready = 1'b1;
          stray_pulse   = dm_resp_valid;
          if (w_sel0 | w_sel1) begin
            w_state_nxt = S_REQ;
          end
        end
      end
      S_REQ: begin
        dm_req_valid = 1'b1;
        if (dm_req_ready) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        dm_resp_ready = 1'b1;
        if (dm_resp_valid) begin
          w_state_nxt = S_RESP;
        end else if (w_timeout_hit) begin
          timeout_pulse = 1'b1;
          w_state_nxt   = S_RESP;
        end
      end
      S_RESP: begin
        dm_resp_ready = 1'b1;
        stray_pulse   = dm_resp_valid;
        m0_resp_valid = ~r_grant;
        m1_resp_valid = r_grant;
        if (w_resp_hs) begin
          w_state_nxt = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      r_state      <= S_IDLE;
      r_req_buf    <= '0;
      r_resp_buf   <= '0;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_timer      <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (w_sel0 | w_sel1) begin
            r_req_buf <= w_sel1 ? m1_req_bits : m0_req_bits;
            r_grant   <= w_sel1;
          end
        end
        S_REQ: begin
          if (dm_req_ready) begin
            r_timer <= '0;
          end
        end
        S_WAIT: begin
          if (r_timer != c_TMR_MAX) begin
            r_timer <= r_timer + TMR_W'(1);
          end
          if (dm_resp_valid) begin
            r_resp_buf <= dm_resp_bits;
          end else if (w_timeout_hit) begin
            r_resp_buf <= {{DATA_W{1'b0}}, 2'b10};
          end
        end
        S_RESP: begin
          if (w_resp_hs) begin
            r_last_grant <= r_grant;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmi_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_dmi_arbiter                                                    |
// | Brief  : Scenario bench for dmi_arbiter with a response scoreboard.        |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_dmi_arbiter;

  localparam int ADDR_W  = 7;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;
  localparam int M_W     = ADDR_W + DATA_W + 2;
  localparam int S_W     = DATA_W + 2;

  logic           sys_clk;
  logic           sys_rstn;
  logic           m0_req_valid, m0_req_ready, m0_resp_valid, m0_resp_ready;
  logic           m1_req_valid, m1_req_ready, m1_resp_valid, m1_resp_ready;
  logic [M_W-1:0] m0_req_bits, m1_req_bits, dm_req_bits;
  logic [S_W-1:0] m0_resp_bits, m1_resp_bits, dm_resp_bits;
  logic           dm_req_valid, dm_req_ready, dm_resp_valid, dm_resp_ready;
  logic           busy, timeout_pulse, stray_pulse;

  typedef struct {
    int             m;
    logic [S_W-1:0] bits;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  dmi_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) u_dut (
    .sys_clk      (sys_clk),
    .sys_rstn     (sys_rstn),
    .m0_req_valid (m0_req_valid),
    .m0_req_ready (m0_req_ready),
    .m0_req_bits  (m0_req_bits),
    .m0_resp_valid(m0_resp_valid),
    .m0_resp_ready(m0_resp_ready),
    .m0_resp_bits (m0_resp_bits),
    .m1_req_valid (m1_req_valid),
    .m1_req_ready (m1_req_ready),
    .m1_req_bits  (m1_req_bits),
    .m1_resp_valid(m1_resp_valid),
    .m1_resp_ready(m1_resp_ready),
    .m1_resp_bits (m1_resp_bits),
    .dm_req_valid (dm_req_valid),
    .dm_req_ready (dm_req_ready),
    .dm_req_bits  (dm_req_bits),
    .dm_resp_valid(dm_resp_valid),
    .dm_resp_ready(dm_resp_ready),
    .dm_resp_bits (dm_resp_bits),
    .busy         (busy),
    .timeout_pulse(timeout_pulse),
    .stray_pulse  (stray_pulse)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  function automatic logic [M_W-1:0] mk_req(input logic [6:0] a, input logic [31:0] d,
                                            input logic [1:0] op);
    return {a, d, op};
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    sys_rstn = 1'b0;
    #1;
    repeat (2) tick();
    sys_rstn = 1'b1;
    #1;
  endtask

  // Raise one master's request and wait for the grant; leaves the FSM in REQ.
  task automatic issue(input int m, input logic [M_W-1:0] bits);
    int n;
    if (m == 0) begin m0_req_valid = 1'b1; m0_req_bits = bits; end
    else        begin m1_req_valid = 1'b1; m1_req_bits = bits; end
    #1;
    n = 0;
    while (((m == 0) ? m0_req_ready : m1_req_ready) !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL req_grant m%0d: req_ready stayed 0, required 1", m);
    end
    checks++;
    if (((m == 0) ? m1_req_ready : m0_req_ready) !== 1'b0) begin
      errors++;
      $display("FAIL req_exclusive m%0d: other req_ready=1, required 0", m);
    end
    tick();
    if (m == 0) m0_req_valid = 1'b0; else m1_req_valid = 1'b0;
  endtask

  // DM side: expects the request one cycle after the grant, stalls ready, then answers.
  task automatic dm_serve(input logic [M_W-1:0] exp_req, input int rdy_dly, input int dly,
                          input logic [S_W-1:0] resp, input int owner);
    checks++;
    if (dm_req_valid !== 1'b1) begin
      errors++;
      $display("FAIL dm_req_latency: dm_req_valid=%b, required 1", dm_req_valid);
    end
    checks++;
    if (dm_req_bits !== exp_req) begin
      errors++;
      $display("FAIL dm_req_bits: got %h, required %h", dm_req_bits, exp_req);
    end
    for (int i = 0; i < rdy_dly; i++) begin
      tick();
      checks++;
      if ({dm_req_valid, dm_req_bits, dm_resp_ready} !== {1'b1, exp_req, 1'b0}) begin
        errors++;
        $display("FAIL dm_req_hold: valid=%b bits=%h resp_ready=%b, required 1/%h/0",
                 dm_req_valid, dm_req_bits, dm_resp_ready, exp_req);
      end
    end
    dm_req_ready = 1'b1;
    tick();
    dm_req_ready = 1'b0;
    repeat (dly) tick();
    dm_resp_valid = 1'b1;
    dm_resp_bits  = resp;
    #1;
    checks++;
    if ({timeout_pulse, stray_pulse, dm_resp_ready} !== 3'b001) begin
      errors++;
      $display("FAIL dm_resp_accept: tmo/stray/ready=%b%b%b, required 001",
               timeout_pulse, stray_pulse, dm_resp_ready);
    end
    sb_q.push_back('{owner, resp});
    tick();
    dm_resp_valid = 1'b0;
    dm_resp_bits  = '0;
  endtask

  // Master side: pop the expected response and check routing, latency and hold stability.
  task automatic get_resp(input int hold);
    exp_t e;
    int   n;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL sb_empty: no expected response queued, required 1");
      return;
    end
    e = sb_q.pop_front();
    n = 0;
    while (((e.m == 0) ? m0_resp_valid : m1_resp_valid) !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL resp_latency m%0d: valid after %0d extra cycles, required 0", e.m, n);
    end
    checks++;
    if (((e.m == 0) ? m0_resp_bits : m1_resp_bits) !== e.bits) begin
      errors++;
      $display("FAIL resp_bits m%0d: got %h, required %h", e.m,
               (e.m == 0) ? m0_resp_bits : m1_resp_bits, e.bits);
    end
    checks++;
    if (((e.m == 0) ? m1_resp_valid : m0_resp_valid) !== 1'b0) begin
      errors++;
      $display("FAIL resp_route m%0d: other resp_valid=1, required 0", e.m);
    end
    for (int i = 0; i < hold; i++) begin
      tick();
      checks++;
      if ({((e.m == 0) ? m0_resp_valid : m1_resp_valid),
           ((e.m == 0) ? m0_resp_bits : m1_resp_bits)} !== {1'b1, e.bits}) begin
        errors++;
        $display("FAIL resp_stable m%0d: got %h, required %h", e.m,
                 (e.m == 0) ? m0_resp_bits : m1_resp_bits, e.bits);
      end
      checks++;
      if ({m0_req_ready, m1_req_ready} !== 2'b00) begin
        errors++;
        $display("FAIL req_ready_busy: got %b%b, required 00", m0_req_ready, m1_req_ready);
      end
    end
    if (e.m == 0) m0_resp_ready = 1'b1; else m1_resp_ready = 1'b1;
    tick();
    m0_resp_ready = 1'b0;
    m1_resp_ready = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_after_resp: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_reset();
    m0_req_valid = 1'b1;
    m1_req_valid = 1'b1;
    sys_rstn     = 1'b0;
    repeat (2) tick();
    checks++;
    if ({busy, dm_req_valid, dm_resp_ready, m0_req_ready, m1_req_ready, m0_resp_valid,
         m1_resp_valid, timeout_pulse, stray_pulse} !== 9'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b, required 0",
               {busy, dm_req_valid, dm_resp_ready, m0_req_ready, m1_req_ready,
                m0_resp_valid, m1_resp_valid, timeout_pulse, stray_pulse});
    end
    checks++;
    if ({dm_req_bits, m0_resp_bits, m1_resp_bits} !== '0) begin
      errors++;
      $display("FAIL reset_bits: got %h %h %h, required 0", dm_req_bits, m0_resp_bits,
               m1_resp_bits);
    end
    m0_req_valid = 1'b0;
    m1_req_valid = 1'b0;
    sys_rstn     = 1'b1;
    tick();
    checks++;
    if ({busy, dm_resp_ready} !== 2'b01) begin
      errors++;
      $display("FAIL idle_after_reset: busy/dm_resp_ready=%b%b, required 01", busy,
               dm_resp_ready);
    end
  endtask

  task automatic test_single();
    logic [M_W-1:0] r;
    r = mk_req(7'h10, 32'h0, 2'b01);
    issue(0, r);
    dm_serve(r, 0, 2, {32'h1234_5678, 2'b00}, 0);
    get_resp(0);
  endtask

  task automatic test_round_robin();
    logic [M_W-1:0] r0, r1;
    int             exp_m;
    do_reset();
    m0_req_valid = 1'b1;
    m1_req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_m       = i % 2;
      r0          = mk_req(7'h20 + 7'(i), 32'h100 + 32'(i), 2'b01);
      r1          = mk_req(7'h40 + 7'(i), 32'h200 + 32'(i), 2'b10);
      m0_req_bits = r0;
      m1_req_bits = r1;
      #1;
      checks++;
      if ({m0_req_ready, m1_req_ready} !== ((exp_m == 0) ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL rr_grant txn%0d: ready m0/m1=%b%b, required m%0d only", i,
                 m0_req_ready, m1_req_ready, exp_m);
      end
      tick();
      dm_serve((exp_m == 0) ? r0 : r1, 0, i, {32'hA000_0000 + 32'(i), 2'b00}, exp_m);
      get_resp(i % 2);
    end
    m0_req_valid = 1'b0;
    m1_req_valid = 1'b0;
  endtask

  task automatic test_timeout();
    logic [M_W-1:0] r;
    int             n;
    r = mk_req(7'h11, 32'h0, 2'b01);
    issue(0, r);
    checks++;
    if (dm_req_valid !== 1'b1) begin
      errors++;
      $display("FAIL tmo_dm_req: dm_req_valid=%b, required 1", dm_req_valid);
    end
    dm_req_ready = 1'b1;
    tick();
    dm_req_ready = 1'b0;
    // First WAIT cycle has timer 0, so the pulse lands TIMEOUT-1 cycles later.
    n = 0;
    while (timeout_pulse !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n != TIMEOUT - 1) begin
      errors++;
      $display("FAIL tmo_delay: pulse after %0d WAIT cycles, required %0d", n, TIMEOUT - 1);
    end
    sb_q.push_back('{0, {32'h0, 2'b10}});
    tick();
    checks++;
    if (timeout_pulse !== 1'b0) begin
      errors++;
      $display("FAIL tmo_pulse_width: pulse=%b second cycle, required 0", timeout_pulse);
    end
    get_resp(2);
    // DM answer on the very cycle the timer expires takes priority.
    r = mk_req(7'h12, 32'hFFFF_0000, 2'b10);
    issue(1, r);
    dm_serve(r, 0, TIMEOUT - 1, {32'h00C0_FFEE, 2'b00}, 1);
    get_resp(0);
  endtask

  task automatic test_stray();
    logic [M_W-1:0] r;
    dm_resp_valid = 1'b1;
    dm_resp_bits  = {32'h0000_DEAD, 2'b00};
    #1;
    checks++;
    if ({stray_pulse, m0_resp_valid, m1_resp_valid, busy} !== 4'b1000) begin
      errors++;
      $display("FAIL stray_idle: stray/r0/r1/busy=%b%b%b%b, required 1000", stray_pulse,
               m0_resp_valid, m1_resp_valid, busy);
    end
    tick();
    dm_resp_valid = 1'b0;
    dm_resp_bits  = '0;
    #1;
    checks++;
    if ({stray_pulse, m0_resp_valid, m1_resp_valid, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL stray_after: stray/r0/r1/busy=%b%b%b%b, required 0000", stray_pulse,
               m0_resp_valid, m1_resp_valid, busy);
    end
    r = mk_req(7'h13, 32'h5A5A_5A5A, 2'b10);
    issue(0, r);
    dm_serve(r, 1, 1, {32'h5555_AAAA, 2'b01}, 0);
    get_resp(0);
  endtask

  task automatic test_back_to_back();
    logic [M_W-1:0] r0, r1;
    r1 = mk_req(7'h21, 32'h1111_2222, 2'b01);
    r0 = mk_req(7'h22, 32'h3333_4444, 2'b10);
    issue(1, r1);
    m0_req_valid = 1'b1;
    m0_req_bits  = r0;
    dm_serve(r1, 3, 0, {32'h7777_8888, 2'b00}, 1);
    get_resp(10);
    checks++;
    if ({m0_req_ready, m1_req_ready} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_next_grant: ready m0/m1=%b%b, required 10", m0_req_ready,
               m1_req_ready);
    end
    tick();
    m0_req_valid = 1'b0;
    dm_serve(r0, 0, 0, {32'h9999_0000, 2'b01}, 0);
    get_resp(0);
  endtask

  task automatic test_reset_abort();
    logic [M_W-1:0] r;
    r = mk_req(7'h30, 32'hABCD_0123, 2'b01);
    issue(0, r);
    dm_req_ready = 1'b1;
    tick();
    dm_req_ready = 1'b0;
    repeat (3) tick();
    m0_req_valid = 1'b1;
    m1_req_valid = 1'b1;
    r            = mk_req(7'h31, 32'h0F0F_0F0F, 2'b10);
    m0_req_bits  = r;
    m1_req_bits  = mk_req(7'h32, 32'hF0F0_F0F0, 2'b01);
    sys_rstn     = 1'b0;
    #1;
    checks++;
    if ({busy, dm_req_valid, dm_resp_ready, m0_req_ready, m1_req_ready, m0_resp_valid,
         m1_resp_valid, timeout_pulse, stray_pulse} !== 9'b0) begin
      errors++;
      $display("FAIL abort_outputs: got %b, required 0",
               {busy, dm_req_valid, dm_resp_ready, m0_req_ready, m1_req_ready,
                m0_resp_valid, m1_resp_valid, timeout_pulse, stray_pulse});
    end
    repeat (2) tick();
    sys_rstn = 1'b1;
    #1;
    checks++;
    if ({m0_req_ready, m1_req_ready, m0_resp_valid, m1_resp_valid} !== 4'b1000) begin
      errors++;
      $display("FAIL abort_regrant: rdy0/rdy1/rv0/rv1=%b%b%b%b, required 1000",
               m0_req_ready, m1_req_ready, m0_resp_valid, m1_resp_valid);
    end
    tick();
    m0_req_valid = 1'b0;
    m1_req_valid = 1'b0;
    dm_serve(r, 0, 1, {32'h2468_ACE0, 2'b00}, 0);
    get_resp(0);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d entries, required 0", sb_q.size());
    end
  endtask

  initial begin
    sys_rstn      = 1'b0;
    m0_req_valid  = 1'b0;
    m1_req_valid  = 1'b0;
    m0_req_bits   = '0;
    m1_req_bits   = '0;
    m0_resp_ready = 1'b0;
    m1_resp_ready = 1'b0;
    dm_req_ready  = 1'b0;
    dm_resp_valid = 1'b0;
    dm_resp_bits  = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_stray();
    test_back_to_back();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
